// File: rtl/buff_pkg.sv
// Shared types, grid geometry and random-source helpers for the buff spawner.
package buff_pkg;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      ACTIVE = 2'd1,
      FLASH  = 2'd2
   } buff_state_t;

   localparam int CELL_SIZE = 32;
   localparam int GRID_COLS = 20;
   localparam int GRID_ROWS = 15;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Fibonacci form: feedback is the parity of the tapped bits, shifted in at bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

   function automatic logic [10:0] grid_x(input logic [4:0] raw);
      logic [4:0] col;
      col = (raw >= 5'(GRID_COLS)) ? raw - 5'(GRID_COLS) : raw;
      return 11'(col) * 11'(CELL_SIZE);
   endfunction

   function automatic logic [10:0] grid_y(input logic [3:0] raw);
      logic [3:0] row;
      row = (raw >= 4'(GRID_ROWS)) ? raw - 4'(GRID_ROWS) : raw;
      return 11'(row) * 11'(CELL_SIZE);
   endfunction

endpackage

// File: rtl/buff_spawner_slot.sv
// One buff slot: wait/active/flash lifecycle, respawn timer, lifetime,
// latched position and the one-cycle collected pulse.
module buff_slot
   import buff_pkg::*;
#(
   parameter int SLOT_IDX   = 0,
   parameter int LIFETIME   = 8,
   parameter int FLASH_TIME = 3,
   parameter int MIN_DELAY  = 3
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        countEn,
   input  logic        one_sec,
   input  logic        gameOver,
   input  logic        collision,
   input  logic        grant,
   input  logic [10:0] spawn_x,
   input  logic [10:0] spawn_y,
   input  logic [3:0]  respawn_delay,
   output logic        spawn_req,
   output logic        visible,
   output logic        active,
   output logic        flashing,
   output logic        collected,
   output logic [10:0] pos_x,
   output logic [10:0] pos_y
);

   localparam logic [3:0] RESET_TIMER = 4'(MIN_DELAY + SLOT_IDX);
   localparam logic [3:0] LIFE_LOAD   = 4'(LIFETIME);
   localparam logic [3:0] FLASH_LIFE  = 4'(FLASH_TIME);

   buff_state_t state, state_next;
   logic [3:0]  timer, timer_next;
   logic [3:0]  life, life_next;
   logic [10:0] x_next, y_next;
   logic        collected_next;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= WAIT;
         timer     <= RESET_TIMER;
         life      <= '0;
         pos_x     <= '0;
         pos_y     <= '0;
         collected <= 1'b0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         life      <= life_next;
         pos_x     <= x_next;
         pos_y     <= y_next;
         collected <= collected_next;
      end
   end

   assign spawn_req = countEn & ~gameOver & one_sec & (state == WAIT) & (timer == 4'd0);

   // Collision is checked before the tick so a pickup on the expiry cycle still pulses.
   always_comb begin
      state_next     = state;
      timer_next     = timer;
      life_next      = life;
      x_next         = pos_x;
      y_next         = pos_y;
      collected_next = 1'b0;
      if (gameOver) begin
         state_next = WAIT;
         timer_next = RESET_TIMER;
      end else if (countEn) begin
         case (state)
            WAIT: begin
               if (one_sec) begin
                  if (timer != 4'd0) begin
                     timer_next = timer - 4'd1;
                  end else if (grant) begin
                     state_next = ACTIVE;
                     life_next  = LIFE_LOAD;
                     x_next     = spawn_x;
                     y_next     = spawn_y;
                  end
               end
            end
            ACTIVE, FLASH: begin
               if (collision) begin
                  collected_next = 1'b1;
                  state_next     = WAIT;
                  timer_next     = respawn_delay;
               end else if (one_sec) begin
                  life_next = life - 4'd1;
                  if (state == ACTIVE && life_next == FLASH_LIFE) begin
                     state_next = FLASH;
                  end else if (state == FLASH && life_next == 4'd0) begin
                     state_next = WAIT;
                     timer_next = respawn_delay;
                  end
               end
            end
            default: state_next = WAIT;
         endcase
      end
   end

   assign visible  = (state != WAIT);
   assign active   = (state == ACTIVE);
   assign flashing = (state == FLASH);

endmodule

// File: rtl/buff_spawner.sv
// Buff producer: random cell picker, lowest-index spawn arbiter with occupancy
// check, blink generator and the per-slot lifecycle instances.
module buff_spawner
   import buff_pkg::*;
#(
   parameter int NUM_BUFFS    = 4,
   parameter int LIFETIME     = 8,
   parameter int FLASH_TIME   = 3,
   parameter int MIN_DELAY    = 3,
   parameter int DELAY_BITS   = 3,
   parameter int BLINK_FRAMES = 8
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 countEn,
   input  logic                 one_sec,
   input  logic                 startOfFrame,
   input  logic                 gameOver,
   input  logic [NUM_BUFFS-1:0] collisionTank1Buff,
   input  logic [NUM_BUFFS-1:0] collisionTank2Buff,
   output logic [NUM_BUFFS-1:0] buffVisible,
   output logic [NUM_BUFFS-1:0] buffDrawEn,
   output logic [10:0]          buffTopLeftX [NUM_BUFFS],
   output logic [10:0]          buffTopLeftY [NUM_BUFFS],
   output logic [NUM_BUFFS-1:0] buffCollected
);

   localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

   logic [15:0]          lfsr;
   logic [10:0]          cand_x;
   logic [10:0]          cand_y;
   logic [3:0]           respawn_delay;
   logic [NUM_BUFFS-1:0] spawn_req;
   logic [NUM_BUFFS-1:0] grant;
   logic [NUM_BUFFS-1:0] slot_active;
   logic [NUM_BUFFS-1:0] slot_flash;
   logic                 occupied;
   logic [FRAME_W-1:0]   frame_cnt;
   logic                 blink_phase;

   // Free-running so the spawn pattern depends on when players act.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign cand_x        = grid_x(lfsr[4:0]);
   assign cand_y        = grid_y(lfsr[8:5]);
   assign respawn_delay = 4'(MIN_DELAY) + 4'(lfsr[8+DELAY_BITS:9]);

   always_comb begin
      occupied = 1'b0;
      for (int j = 0; j < NUM_BUFFS; j++) begin
         if (buffVisible[j] && buffTopLeftX[j] == cand_x && buffTopLeftY[j] == cand_y) begin
            occupied = 1'b1;
         end
      end
   end

   // Isolate the lowest set request bit; a taken cell blocks everyone this cycle.
   assign grant = occupied ? '0 : (spawn_req & (~spawn_req + NUM_BUFFS'(1)));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (startOfFrame) begin
         if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_BUFFS; i++) begin : g_slot
      buff_slot #(
         .SLOT_IDX   (i),
         .LIFETIME   (LIFETIME),
         .FLASH_TIME (FLASH_TIME),
         .MIN_DELAY  (MIN_DELAY)
      ) u_slot (
         .clk           (clk),
         .resetN        (resetN),
         .countEn       (countEn),
         .one_sec       (one_sec),
         .gameOver      (gameOver),
         .collision     (collisionTank1Buff[i] | collisionTank2Buff[i]),
         .grant         (grant[i]),
         .spawn_x       (cand_x),
         .spawn_y       (cand_y),
         .respawn_delay (respawn_delay),
         .spawn_req     (spawn_req[i]),
         .visible       (buffVisible[i]),
         .active        (slot_active[i]),
         .flashing      (slot_flash[i]),
         .collected     (buffCollected[i]),
         .pos_x         (buffTopLeftX[i]),
         .pos_y         (buffTopLeftY[i])
      );

      assign buffDrawEn[i] = slot_active[i] | (slot_flash[i] & blink_phase);
   end

endmodule

// File: tb/tb_buff_spawner.sv
// Directed bench for buff_spawner: a per-tick vector table plus hand sequences
// for blink, expiry/collision races, freeze, arbitration and async reset.
module tb_buff_spawner;

   logic        clk = 1'b0;
   logic        resetN;
   logic        countEn;
   logic        one_sec;
   logic        startOfFrame;
   logic        gameOver;
   logic [3:0]  collisionTank1Buff;
   logic [3:0]  collisionTank2Buff;
   logic [3:0]  buffVisible;
   logic [3:0]  buffDrawEn;
   logic [10:0] buff_x [4];
   logic [10:0] buff_y [4];
   logic [3:0]  buffCollected;

   int   total = 0;
   int   bad = 0;
   int   pulse_cnt [4];
   logic sof_en = 1'b0;
   logic [2:0] m_cnt;
   logic m_phase;

   typedef struct {
      logic       en;
      logic       go;
      logic [3:0] c1;
      logic [3:0] c2;
      logic [3:0] vis;
      logic [3:0] draw;
      logic [3:0] coll;
   } vec_t;

   vec_t vecs [19];

   buff_spawner dut (
      .clk                (clk),
      .resetN             (resetN),
      .countEn            (countEn),
      .one_sec            (one_sec),
      .startOfFrame       (startOfFrame),
      .gameOver           (gameOver),
      .collisionTank1Buff (collisionTank1Buff),
      .collisionTank2Buff (collisionTank2Buff),
      .buffVisible        (buffVisible),
      .buffDrawEn         (buffDrawEn),
      .buffTopLeftX       (buff_x),
      .buffTopLeftY       (buff_y),
      .buffCollected      (buffCollected)
   );

   always #5 clk = ~clk;

   initial begin
      startOfFrame = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         startOfFrame = sof_en & ~startOfFrame;
      end
   end

   // Reference blink phase: toggles after every eighth frame tick.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_cnt   <= 3'd0;
         m_phase <= 1'b0;
      end else if (startOfFrame) begin
         if (m_cnt == 3'd7) begin
            m_cnt   <= 3'd0;
            m_phase <= ~m_phase;
         end else begin
            m_cnt <= m_cnt + 3'd1;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic tick, input logic [3:0] c1, input logic [3:0] c2);
      one_sec = tick;
      collisionTank1Buff = c1;
      collisionTank2Buff = c2;
      @(posedge clk);
      #1;
      one_sec = 1'b0;
      collisionTank1Buff = '0;
      collisionTank2Buff = '0;
      for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(buffCollected[i]);
   endtask

   task automatic applyTick(input logic [3:0] c1, input logic [3:0] c2);
      applyStimulus(1'b1, c1, c2);
      repeat (9) applyStimulus(1'b0, 4'h0, 4'h0);
   endtask

   task automatic doReset();
      resetN = 1'b0;
      countEn = 1'b0;
      one_sec = 1'b0;
      gameOver = 1'b0;
      collisionTank1Buff = '0;
      collisionTank2Buff = '0;
      sof_en = 1'b0;
      for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      countEn = 1'b1;
   endtask

   initial begin
      int   steady_err, blink_err, vis_err, early_err;
      logic seen0, seen1, found, vis1_at;

      vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
      vecs[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0};
      vecs[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h7, 4'h7, 4'h0};
      vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
      vecs[7]  = '{1'b1, 1'b0, 4'h4, 4'h4, 4'hB, 4'hB, 4'h4};
      vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hB, 4'hA, 4'h0};
      vecs[9]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'hB, 4'hA, 4'h0};
      vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h2, 4'hB, 4'hA, 4'h0};
      vecs[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hB, 4'h8, 4'h0};
      vecs[12] = '{1'b1, 1'b0, 4'h1, 4'h0, 4'hA, 4'h8, 4'h1};
      vecs[13] = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[14] = '{1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
      vecs[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[16] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[17] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[18] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};

      // reset state
      resetN = 1'b0;
      countEn = 1'b0;
      one_sec = 1'b0;
      gameOver = 1'b0;
      collisionTank1Buff = '0;
      collisionTank2Buff = '0;
      #12;
      checkOutput("rst_vis", 32'(buffVisible), 32'h0);
      checkOutput("rst_draw", 32'(buffDrawEn), 32'h0);
      checkOutput("rst_coll", 32'(buffCollected), 32'h0);
      checkOutput("rst_x0", 32'(buff_x[0]), 32'h0);
      checkOutput("rst_y3", 32'(buff_y[3]), 32'h0);

      // table: one tick per entry
      doReset();
      for (int i = 0; i < 19; i++) begin
         countEn = vecs[i].en;
         gameOver = vecs[i].go;
         applyStimulus(1'b1, vecs[i].c1, vecs[i].c2);
         checkOutput($sformatf("vec%0d_vis", i), 32'(buffVisible), 32'(vecs[i].vis));
         checkOutput($sformatf("vec%0d_draw", i), 32'(buffDrawEn), 32'(vecs[i].draw));
         checkOutput($sformatf("vec%0d_coll", i), 32'(buffCollected), 32'(vecs[i].coll));
         applyStimulus(1'b0, 4'h0, 4'h0);
         checkOutput($sformatf("vec%0d_coll_after", i), 32'(buffCollected), 32'h0);
         repeat (8) applyStimulus(1'b0, 4'h0, 4'h0);
      end

      // blink: steady for 5 ticks, then follows the 8-frame blink phase
      doReset();
      sof_en = 1'b1;
      steady_err = 0; blink_err = 0; vis_err = 0; seen0 = 1'b0; seen1 = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         for (int c = 0; c < 10; c++) begin
            applyStimulus(c == 0, 4'h0, 4'h0);
            if (t >= 4 && t <= 8 && buffDrawEn[0] !== 1'b1) steady_err++;
            if (t >= 9 && t <= 11) begin
               if (buffVisible[0] !== 1'b1) vis_err++;
               if (buffDrawEn[0] !== m_phase) blink_err++;
               if (buffDrawEn[0]) seen1 = 1'b1; else seen0 = 1'b1;
            end
         end
      end
      checkOutput("blink_steady_err", 32'(steady_err), 32'h0);
      checkOutput("blink_phase_err", 32'(blink_err), 32'h0);
      checkOutput("blink_vis_err", 32'(vis_err), 32'h0);
      checkOutput("blink_toggled", 32'({seen0, seen1}), 32'h3);
      checkOutput("expire_vis0", 32'(buffVisible[0]), 32'h0);
      checkOutput("expire_no_pulse", 32'(pulse_cnt[0]), 32'h0);

      // held double-tank hit and collision on the final flash tick
      doReset();
      early_err = 0;
      for (int t = 1; t <= 12; t++) begin
         for (int c = 0; c < 10; c++) begin
            logic [3:0] c1v, c2v;
            c1v = 4'h0; c2v = 4'h0;
            if (t == 8 && c < 3) begin c1v = 4'h4; c2v = 4'h4; end
            if (t == 12 && c == 0) c1v = 4'h1;
            if (t == 8 && c == 0) checkOutput("hit2_pre_vis", 32'(buffVisible[2]), 32'h1);
            if (t == 12 && c == 0) checkOutput("final_pre_vis_draw", 32'({buffVisible[0], buffDrawEn[0]}), 32'h2);
            applyStimulus(c == 0, c1v, c2v);
            if (t == 8 && c == 0) checkOutput("hit2_vis_next", 32'(buffVisible[2]), 32'h0);
            if (t >= 9 && t <= 11 && buffVisible[2]) early_err++;
            if (t == 12 && c == 0) begin
               checkOutput("final_coll_pulse", 32'(buffCollected[0]), 32'h1);
               checkOutput("final_vis0", 32'(buffVisible[0]), 32'h0);
            end
         end
      end
      checkOutput("hit2_pulse_count", 32'(pulse_cnt[2]), 32'h1);
      checkOutput("final_pulse_count", 32'(pulse_cnt[0]), 32'h1);
      checkOutput("respawn_min_delay", 32'(early_err), 32'h0);

      // freeze for 20 ticks while active
      doReset();
      repeat (6) applyTick(4'h0, 4'h0);
      countEn = 1'b0;
      vis_err = 0;
      for (int k = 0; k < 20; k++) begin
         applyTick(4'h1, 4'h0);
         if (buffVisible[0] !== 1'b1) vis_err++;
      end
      checkOutput("freeze_vis_err", 32'(vis_err), 32'h0);
      checkOutput("freeze_no_pulse", 32'(pulse_cnt[0]), 32'h0);
      countEn = 1'b1;
      for (int r = 1; r <= 6; r++) begin
         logic [1:0] exp_vd;
         applyTick(4'h0, 4'h0);
         exp_vd = (r <= 2) ? 2'b11 : (r <= 5) ? 2'b10 : 2'b00;
         checkOutput($sformatf("resume%0d_vis_draw", r), 32'({buffVisible[0], buffDrawEn[0]}), 32'(exp_vd));
      end

      // simultaneous requests: slot 0 wins, slot 1 follows on a later tick
      doReset();
      repeat (5) applyTick(4'h0, 4'h0);
      checkOutput("first_two_vis", 32'(buffVisible[1:0]), 32'h3);
      checkOutput("pos0_x_align", 32'(buff_x[0][4:0]), 32'h0);
      checkOutput("pos0_y_align", 32'(buff_y[0][4:0]), 32'h0);
      checkOutput("pos1_x_align", 32'(buff_x[1][4:0]), 32'h0);
      checkOutput("pos1_y_align", 32'(buff_y[1][4:0]), 32'h0);
      checkOutput("pos_range", 32'({buff_x[0] < 11'd640, buff_y[0] < 11'd480, buff_x[1] < 11'd640, buff_y[1] < 11'd480}), 32'hF);
      checkOutput("pos01_differ", 32'((buff_x[0] != buff_x[1]) || (buff_y[0] != buff_y[1])), 32'h1);
      applyStimulus(1'b0, 4'h3, 4'h0);
      checkOutput("both_coll", 32'(buffCollected[1:0]), 32'h3);
      checkOutput("both_gone", 32'(buffVisible[1:0]), 32'h0);
      repeat (9) applyStimulus(1'b0, 4'h0, 4'h0);
      found = 1'b0; vis1_at = 1'b1;
      for (int k = 0; k < 15 && !found; k++) begin
         applyTick(4'h0, 4'h0);
         if (buffVisible[0]) begin found = 1'b1; vis1_at = buffVisible[1]; end
      end
      checkOutput("arb_slot0_spawn", 32'(found), 32'h1);
      checkOutput("arb_slot1_waits", 32'(vis1_at), 32'h0);
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         applyTick(4'h0, 4'h0);
         if (buffVisible[1]) found = 1'b1;
      end
      checkOutput("arb_slot1_retry", 32'(found), 32'h1);
      checkOutput("arb_cells_differ", 32'((buff_x[0] != buff_x[1]) || (buff_y[0] != buff_y[1])), 32'h1);

      // asynchronous reset mid-flash
      doReset();
      sof_en = 1'b1;
      repeat (10) applyTick(4'h0, 4'h0);
      checkOutput("pre_areset_vis0", 32'(buffVisible[0]), 32'h1);
      @(posedge clk);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput("areset_vis", 32'(buffVisible), 32'h0);
      checkOutput("areset_draw", 32'(buffDrawEn), 32'h0);
      checkOutput("areset_coll", 32'(buffCollected), 32'h0);
      checkOutput("areset_pos0", 32'({buff_x[0], buff_y[0]}), 32'h0);
      sof_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
